cnnip_pool: RTL

Post-convolution stage of the CNN IP: once the convolution controller has filled the feature memory, this block reads the square feature map back, applies optional ReLU and optional 2×2/stride-2 max-pooling, and writes the result into the output memory region. It sits directly downstream of the convolution controller. It is launched by its own command register pair and reports completion the same way the controller does.

---
 rtl/cnnip_pool_pkg.sv | 15 +
 rtl/cnnip_pool_addr_gen.sv | 89 ++++++++
 rtl/cnnip_pool.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cnnip_pool_pkg.sv
// rtl/cnnip_pool_pkg.sv - shared types and constants for the pooling stage
package cnnip_pool_pkg;

    typedef enum logic [2:0] {IDLE, RD, WT, WR, DONE} pool_state_t;

    localparam int unsigned FM_BASE_DEFAULT = 32'h300;
    localparam int unsigned OM_BASE_DEFAULT = 32'h800;
    localparam int unsigned MAX_MAP_SIZE    = 16;

    // Output side length: pooling halves the map, dropping an odd last row/column
    function automatic logic [7:0] out_size_of(input logic [7:0] map_size, input logic pool);
        return pool ? (map_size >> 1) : map_size;
    endfunction

endpackage

// File: rtl/cnnip_pool_addr_gen.sv
// rtl/cnnip_pool_addr_gen.sv - window/output counters and feature/output address generation
module cnnip_pool_addr_gen
    import cnnip_pool_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter int unsigned FM_BASE    = FM_BASE_DEFAULT,
    parameter int unsigned OM_BASE    = OM_BASE_DEFAULT
) (
    input  logic                  clk_a,
    input  logic                  srst_aq,
    input  logic                  start,
    input  logic                  adv_w,
    input  logic                  adv_o,
    input  logic                  pool,
    input  logic [7:0]            map_size,
    input  logic [7:0]            out_size,
    output logic                  w_first,
    output logic                  w_last,
    output logic                  o_last,
    output logic [ADDR_WIDTH-1:0] fm_addr,
    output logic [ADDR_WIDTH-1:0] om_addr
);

    localparam int CW = $clog2(MAX_MAP_SIZE);
    localparam logic [ADDR_WIDTH-1:0] FM_BASE_A = ADDR_WIDTH'(FM_BASE);
    localparam logic [ADDR_WIDTH-1:0] OM_BASE_A = ADDR_WIDTH'(OM_BASE);

    logic [CW-1:0]         ox, oy, ox_n, oy_n;
    logic [1:0]            w, w_n;
    logic                  ox_last, oy_last;
    logic [15:0]           row_n, col_n, fm_idx_n, om_idx_n;
    logic [ADDR_WIDTH-1:0] fm_addr_n, om_addr_n;

    assign w_first = (w == 2'd0);
    assign w_last  = pool ? (w == 2'd3) : 1'b1;
    assign ox_last = (8'(ox) == out_size - 8'd1);
    assign oy_last = (8'(oy) == out_size - 8'd1);
    assign o_last  = ox_last && oy_last;

    // Next counter values: w fastest, then ox, then oy
    always_comb begin
        w_n  = w;
        ox_n = ox;
        oy_n = oy;
        if (start) begin
            w_n  = '0;
            ox_n = '0;
            oy_n = '0;
        end else if (adv_w) begin
            w_n = w + 2'd1;
        end else if (adv_o) begin
            w_n = '0;
            if (ox_last) begin
                ox_n = '0;
                oy_n = oy + CW'(1);
            end else begin
                ox_n = ox + CW'(1);
            end
        end
    end

    // Addresses are computed from the next counters so they are registered in step with them
    always_comb begin
        row_n     = (16'(oy_n) << pool) + 16'(pool & w_n[1]);
        col_n     = (16'(ox_n) << pool) + 16'(pool & w_n[0]);
        fm_idx_n  = row_n * 16'(map_size) + col_n;
        om_idx_n  = 16'(oy_n) * 16'(out_size) + 16'(ox_n);
        fm_addr_n = FM_BASE_A + ADDR_WIDTH'({fm_idx_n, 2'b00});
        om_addr_n = OM_BASE_A + ADDR_WIDTH'({om_idx_n, 2'b00});
    end

    // Counter and address registers
    always_ff @(posedge clk_a) begin
        if (srst_aq) begin
            w       <= '0;
            ox      <= '0;
            oy      <= '0;
            fm_addr <= FM_BASE_A;
            om_addr <= OM_BASE_A;
        end else begin
            w       <= w_n;
            ox      <= ox_n;
            oy      <= oy_n;
            fm_addr <= fm_addr_n;
            om_addr <= om_addr_n;
        end
    end

endmodule

// File: rtl/cnnip_pool.sv
// rtl/cnnip_pool.sv - ReLU and 2x2 max-pool post-processing of the feature map
module cnnip_pool
    import cnnip_pool_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 12,
    parameter int unsigned FM_BASE    = FM_BASE_DEFAULT,
    parameter int unsigned OM_BASE    = OM_BASE_DEFAULT
) (
    input  logic                  clk_a,
    input  logic                  srst_aq,
    input  logic                  CMD_START,
    input  logic [7:0]            MAP_SIZE,
    input  logic                  MODE_RELU,
    input  logic                  MODE_POOL,
    output logic                  CMD_DONE,
    output logic                  CMD_DONE_VALID,
    output logic                  fm_en,
    output logic                  fm_we,
    output logic [ADDR_WIDTH-1:0] fm_addr,
    input  logic [DATA_WIDTH-1:0] fm_dout,
    input  logic                  fm_valid,
    output logic                  om_en,
    output logic                  om_we,
    output logic [ADDR_WIDTH-1:0] om_addr,
    output logic [DATA_WIDTH-1:0] om_din
);

    pool_state_t           state;
    logic [7:0]            map_q, out_q, start_out;
    logic                  pool_q, relu_q;
    logic [DATA_WIDTH-1:0] acc, v, acc_n, om_din_q;
    logic                  done_q, fm_en_q, om_en_q;
    logic                  start, adv_w, adv_o;
    logic                  w_first, w_last, o_last;

    assign start_out = out_size_of(MAP_SIZE, MODE_POOL);
    assign start     = (state == IDLE) && CMD_START;
    assign adv_w     = (state == WT) && fm_valid && !w_last;
    assign adv_o     = (state == WR);

    // ReLU on the incoming word, then running signed max over the window
    always_comb begin
        v     = (relu_q && fm_dout[DATA_WIDTH-1]) ? '0 : fm_dout;
        acc_n = (w_first || ($signed(v) > $signed(acc))) ? v : acc;
    end

    cnnip_pool_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .FM_BASE    (FM_BASE),
        .OM_BASE    (OM_BASE)
    ) u_addr_gen (
        .clk_a    (clk_a),
        .srst_aq  (srst_aq),
        .start    (start),
        .adv_w    (adv_w),
        .adv_o    (adv_o),
        .pool     (pool_q),
        .map_size (map_q),
        .out_size (out_q),
        .w_first  (w_first),
        .w_last   (w_last),
        .o_last   (o_last),
        .fm_addr  (fm_addr),
        .om_addr  (om_addr)
    );

    // Control FSM with registered strobes, latched config and accumulator
    always_ff @(posedge clk_a) begin
        if (srst_aq) begin
            state    <= IDLE;
            map_q    <= '0;
            out_q    <= '0;
            pool_q   <= 1'b0;
            relu_q   <= 1'b0;
            acc      <= '0;
            om_din_q <= '0;
            done_q   <= 1'b0;
            fm_en_q  <= 1'b0;
            om_en_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CMD_START) begin
                        map_q  <= MAP_SIZE;
                        pool_q <= MODE_POOL;
                        relu_q <= MODE_RELU;
                        out_q  <= start_out;
                        if (start_out == 8'd0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= RD;
                            fm_en_q <= 1'b1;
                        end
                    end
                end
                RD: begin
                    fm_en_q <= 1'b0;
                    state   <= WT;
                end
                WT: begin
                    if (fm_valid) begin
                        acc <= acc_n;
                        if (w_last) begin
                            state    <= WR;
                            om_en_q  <= 1'b1;
                            om_din_q <= acc_n;
                        end else begin
                            state   <= RD;
                            fm_en_q <= 1'b1;
                        end
                    end
                end
                WR: begin
                    om_en_q <= 1'b0;
                    if (o_last) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        state   <= RD;
                        fm_en_q <= 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign CMD_DONE       = done_q;
    assign CMD_DONE_VALID = done_q;
    assign fm_en          = fm_en_q;
    assign fm_we          = 1'b0;
    assign om_en          = om_en_q;
    assign om_we          = om_en_q;
    assign om_din         = om_din_q;

endmodule
